veririsc_datapath: RTL and testbench



---
 rtl/veririsc_datapath.sv | 140 ++++++++++++++
 tb/tb_veririsc_datapath.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/veririsc_datapath.sv
// rtl/veririsc_datapath.sv - VeriRISC execution datapath and phase sequencer
//
// Holds the phase counter, instruction register, program counter,
// accumulator and ALU, and steers memory address and write data.
// The controller decodes the phase, opcode and zero outputs and answers
// with the nine strobes on the inputs.
//
// Ports:
//   clk, rst_               clock, asynchronous active-low reset
//   sel                     address source: 1 = PC, 0 = IR operand field
//   rd, wr                  memory read / write strobes, passed through
//   ld_ir, inc_pc, ld_pc    IR load, PC increment, PC load (ld_pc wins)
//   ld_ac                   AC load from the ALU result
//   data_e                  drive AC onto mem_wdata (else zero)
//   halt                    freeze phase, IR, PC and AC
//   mem_rdata               memory read data (ALU operand, IR source)
//   mem_addr, mem_wdata     memory address and write data
//   mem_rd, mem_wr          memory read / write enables
//   phase, opcode, zero     decode inputs for the controller
//   icount                  completed-instruction count (optional)
//
// Optional feature: define VERIRISC_DATAPATH_ICOUNT_EN to add the
// saturating 16-bit icount output.
//
// ADDR_WIDTH must equal DATA_WIDTH-3 so the IR operand field fills the
// address bus exactly.

module veririsc_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  sel,
    input  logic                  rd,
    input  logic                  ld_ir,
    input  logic                  inc_pc,
    input  logic                  halt,
    input  logic                  ld_pc,
    input  logic                  data_e,
    input  logic                  ld_ac,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [2:0]            phase,
    output logic [2:0]            opcode,
    output logic                  zero
`ifdef VERIRISC_DATAPATH_ICOUNT_EN
    ,
    output logic [15:0]           icount
`endif
);

    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;

    logic [DATA_WIDTH-1:0] ir;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] ac;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [ADDR_WIDTH-1:0] ir_addr;

    assign opcode  = ir[DATA_WIDTH-1 -: 3];
    assign ir_addr = ir[ADDR_WIDTH-1:0];

    // Combinational so the controller sees the new value in the same cycle
    // it decodes SKZ.
    assign zero = (ac == '0);

    assign mem_addr  = sel ? pc : ir_addr;
    assign mem_wdata = data_e ? ac : '0;
    assign mem_rd    = rd;
    assign mem_wr    = wr;

    // Opcodes without an arithmetic role pass AC through, so a stray ld_ac
    // on those leaves AC intact.
    always_comb begin
        alu_out = ac;
        case (opcode)
            OP_ADD:  alu_out = ac + mem_rdata;
            OP_AND:  alu_out = ac & mem_rdata;
            OP_XOR:  alu_out = ac ^ mem_rdata;
            OP_LDA:  alu_out = mem_rdata;
            default: alu_out = ac;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase <= 3'd0;
        end else if (!halt) begin
            phase <= phase + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ir <= '0;
        end else if (!halt && ld_ir) begin
            ir <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pc <= '0;
        end else if (!halt) begin
            if (ld_pc) begin
                pc <= ir_addr;
            end else if (inc_pc) begin
                pc <= pc + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ac <= '0;
        end else if (!halt && ld_ac) begin
            ac <= alu_out;
        end
    end

`ifdef VERIRISC_DATAPATH_ICOUNT_EN
    // An instruction completes on the edge that takes phase from 7 to 0.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            icount <= 16'd0;
        end else if (!halt && phase == 3'd7 && icount != 16'hFFFF) begin
            icount <= icount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_veririsc_datapath.sv
// tb/tb_veririsc_datapath.sv - self-checking bench for veririsc_datapath

`timescale 1ns/100ps

module tb_veririsc_datapath;

    logic       clk;
    logic       rst_;
    logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
    logic [7:0] mem_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_rd, mem_wr;
    logic [2:0] phase, opcode;
    logic       zero;
`ifdef VERIRISC_DATAPATH_ICOUNT_EN
    logic [15:0] icount;
`endif

    veririsc_datapath #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_(rst_),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt),
        .ld_pc(ld_pc), .data_e(data_e), .ld_ac(ld_ac), .wr(wr),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .phase(phase), .opcode(opcode), .zero(zero)
`ifdef VERIRISC_DATAPATH_ICOUNT_EN
        , .icount(icount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [32];

    always_comb mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] instr;
        logic [4:0] pc;
        logic [7:0] ac;
        logic       z;
    } vec_t;

    localparam int N = 10;
    vec_t tbl [N];
    vec_t sb [$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic clr();
        sel = 0; rd = 0; ld_ir = 0; inc_pc = 0; halt = 0;
        ld_pc = 0; data_e = 0; ld_ac = 0; wr = 0;
    endtask

    // Observe PC, IR operand and AC through the combinational memory paths.
    task automatic peek(output logic [7:0] pc_v, output logic [7:0] irlo_v, output logic [7:0] ac_v);
        sel = 1; data_e = 1;
        #1;
        pc_v = {3'b000, mem_addr};
        ac_v = mem_wdata;
        sel = 0;
        #1;
        irlo_v = {3'b000, mem_addr};
    endtask

    // Reference VeriRISC controller decode.
    task automatic drive_ctrl();
        logic aluop;
        aluop = (opcode inside {3'd2, 3'd3, 3'd4, 3'd5});
        clr();
        case (phase)
            3'd0: sel = 1;
            3'd1: begin sel = 1; rd = 1; end
            3'd2, 3'd3: begin sel = 1; rd = 1; ld_ir = 1; end
            3'd4: begin sel = 1; inc_pc = 1; halt = (opcode == 3'd0); end
            3'd5: rd = aluop;
            3'd6: begin
                rd = aluop; inc_pc = (opcode == 3'd1) && zero;
                ld_pc = (opcode == 3'd7); data_e = (opcode == 3'd6);
            end
            default: begin
                rd = aluop; ld_ac = aluop; ld_pc = (opcode == 3'd7);
                data_e = (opcode == 3'd6); wr = (opcode == 3'd6);
            end
        endcase
    endtask

    // One clock under controller control, entered and left at a negedge.
    task automatic cycle();
        logic       w;
        logic [4:0] a;
        logic [7:0] d;
        drive_ctrl();
        #1;
        w = mem_wr; a = mem_addr; d = mem_wdata;
        @(posedge clk);
        if (w) mem[a] = d;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pc_v, irlo_v, ac_v;
        int         completed;
        int         idx;
        bit         found;
        vec_t       e;

        tbl[0] = '{5'd0,  8'hBA, 5'd1,  8'h05, 1'b0};
        tbl[1] = '{5'd1,  8'h5B, 5'd2,  8'h03, 1'b0};
        tbl[2] = '{5'd2,  8'hBC, 5'd3,  8'h00, 1'b1};
        tbl[3] = '{5'd3,  8'h20, 5'd5,  8'h00, 1'b1};
        tbl[4] = '{5'd5,  8'hBD, 5'd6,  8'h77, 1'b0};
        tbl[5] = '{5'd6,  8'hDE, 5'd7,  8'h77, 1'b0};
        tbl[6] = '{5'd7,  8'h7B, 5'd8,  8'h76, 1'b0};
        tbl[7] = '{5'd8,  8'h9A, 5'd9,  8'h73, 1'b0};
        tbl[8] = '{5'd9,  8'h20, 5'd10, 8'h73, 1'b0};
        tbl[9] = '{5'd10, 8'hEC, 5'd12, 8'h73, 1'b0};

        rst_ = 0;
        clr();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        for (int i = 0; i < N; i++) mem[tbl[i].addr] = tbl[i].instr;
        mem[26] = 8'h05; mem[27] = 8'hFE; mem[28] = 8'h00; mem[29] = 8'h77;

        #1;
        chk("rst_phase", phase, 3'd0);
        chk("rst_opcode", opcode, 3'd0);
        chk("rst_zero", zero, 1'b1);
        peek(pc_v, irlo_v, ac_v);
        chk("rst_pc", pc_v, 8'h00);
        chk("rst_ac", ac_v, 8'h00);

        @(negedge clk);
        rst_ = 1;

        // Program run: expectation queued at fetch, checked at completion.
        completed = 0; idx = 0;
        for (int c = 0; c < 200 && completed < N; c++) begin
            if (phase == 3'd0) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    peek(pc_v, irlo_v, ac_v);
                    chk($sformatf("i%0d_pc", completed), pc_v, {3'b000, e.pc});
                    chk($sformatf("i%0d_ac", completed), ac_v, e.ac);
                    chk($sformatf("i%0d_zero", completed), zero, e.z);
                    chk($sformatf("i%0d_opcode", completed), opcode, e.instr[7:5]);
                    chk($sformatf("i%0d_irlo", completed), irlo_v, {3'b000, e.instr[4:0]});
                    completed++;
                end
                if (idx < N) begin
                    sb.push_back(tbl[idx]);
                    idx++;
                end
            end
            if (completed < N) cycle();
        end
        chk("prog_done", completed, N);
        chk("sto_mem30", mem[30], 8'h77);

        // HLT at address 12 parks the core at phase 4.
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (phase == 3'd4 && opcode == 3'd0) found = 1;
            else cycle();
        end
        chk("hlt_reached", found, 1'b1);
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk($sformatf("hlt_phase_%0d", c), phase, 3'd4);
        end
        peek(pc_v, irlo_v, ac_v);
        chk("hlt_pc", pc_v, 8'h0C);
        chk("hlt_ac", ac_v, 8'h73);

        // Halt must override every load strobe in the same cycle.
        clr();
        halt = 1; ld_ir = 1; rd = 1; ld_pc = 1; ld_ac = 1; inc_pc = 1;
        @(posedge clk);
        @(negedge clk);
        clr();
        halt = 1;
        chk("hlt_ovr_phase", phase, 3'd4);
        chk("hlt_ovr_opcode", opcode, 3'd0);
        peek(pc_v, irlo_v, ac_v);
        chk("hlt_ovr_pc", pc_v, 8'h0C);
        chk("hlt_ovr_ac", ac_v, 8'h73);
`ifdef VERIRISC_DATAPATH_ICOUNT_EN
        chk("icount_frozen", icount, 16'd10);
`endif

        // Asynchronous reset mid-instruction with AC = 0x3C.
        @(negedge clk);
        clr();
        rst_ = 0;
        @(negedge clk);
        mem[0] = 8'hBA; mem[26] = 8'h3C; mem[1] = 8'h20;
        rst_ = 1;
        for (int c = 0; c < 13; c++) cycle();
`ifdef VERIRISC_DATAPATH_ICOUNT_EN
        chk("icount_one", icount, 16'd1);
`endif
        chk("pre_rst_phase", phase, 3'd5);
        peek(pc_v, irlo_v, ac_v);
        chk("pre_rst_ac", ac_v, 8'h3C);
        rst_ = 0;
        #1;
        chk("arst_phase", phase, 3'd0);
        chk("arst_opcode", opcode, 3'd0);
        chk("arst_zero", zero, 1'b1);
        peek(pc_v, irlo_v, ac_v);
        chk("arst_pc", pc_v, 8'h00);
        chk("arst_ac", ac_v, 8'h00);

        // JMP 31 then JMP 9 from address 31: PC wraps 31 -> 0 at phase 4.
        @(negedge clk);
        clr();
        mem[0] = 8'hFF; mem[31] = 8'hE9;
        rst_ = 1;
        for (int c = 0; c < 8; c++) cycle();
        peek(pc_v, irlo_v, ac_v);
        chk("jmp31_pc", pc_v, 8'h1F);
        for (int c = 0; c < 5; c++) cycle();
        peek(pc_v, irlo_v, ac_v);
        chk("pc_wrap", pc_v, 8'h00);
        for (int c = 0; c < 3; c++) cycle();
        peek(pc_v, irlo_v, ac_v);
        chk("jmp9_pc", pc_v, 8'h09);
        chk("jmp9_opcode", opcode, 3'd7);
        chk("jmp9_irlo", irlo_v, 8'h09);

        // ld_pc wins over inc_pc in the same cycle.
        clr();
        ld_pc = 1; inc_pc = 1;
        @(posedge clk);
        @(negedge clk);
        clr();
        peek(pc_v, irlo_v, ac_v);
        chk("prio_pc", pc_v, 8'h09);
        chk("prio_phase", phase, 3'd1);

        // Write with data_e low drives zero data; strobes pass straight through.
        clr();
        wr = 1;
        #1;
        chk("wr_noe_wdata", mem_wdata, 8'h00);
        chk("wr_noe_memwr", mem_wr, 1'b1);
        chk("wr_noe_addr", mem_addr, 5'd9);
        chk("rd_pass_0", mem_rd, 1'b0);
        rd = 1;
        #1;
        chk("rd_pass_1", mem_rd, 1'b1);
        clr();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
